// File: rtl/imm_instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_instr_encoder_pkg
// Shared definitions for the immediate instruction encoder:
//   - fmt_e       : request class carried on in_fmt
//   - OPC_*       : RV32I major opcodes, identical to the core's extractor
//   - F3_*        : funct3 codes that change how the extractor widens imm
//   - *_MIN/*_MAX : value ranges the extractor can hand back exactly
//   - fmt_opcode  : maps a request class onto its opcode
// -----------------------------------------------------------------------------
package imm_instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_OP_IMM = 3'd0,
        FMT_LOAD   = 3'd1,
        FMT_STORE  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_LUI    = 3'd4,
        FMT_AUIPC  = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_ILLEGAL = 7'b0000000;

    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;

    // The only upper-seven patterns a shift immediate may carry (SRLI / SRAI).
    localparam logic [6:0] SHIFT_HI_LOGICAL = 7'h00;
    localparam logic [6:0] SHIFT_HI_ARITH   = 7'h20;

    // Zero-extended 12-bit fields (SLTIU, LOAD, STORE).
    localparam logic [31:0] ZEXT12_MAX = 32'd4095;

    // Sign-extended 12-bit fields (remaining OP_IMM).
    localparam logic signed [31:0] SEXT12_MIN = -32'sd2048;
    localparam logic signed [31:0] SEXT12_MAX = 32'sd2047;

    // Branch offsets: unsigned-compare branches zero-extend, others sign-extend.
    localparam logic [31:0]        BR_ZEXT_MAX = 32'd8190;
    localparam logic signed [31:0] BR_SEXT_MIN = -32'sd4096;
    localparam logic signed [31:0] BR_SEXT_MAX = 32'sd4094;

    function automatic logic [6:0] fmt_opcode(input logic [2:0] fmt);
        logic [6:0] opc;
        case (fmt)
            FMT_OP_IMM: opc = OPC_OP_IMM;
            FMT_LOAD:   opc = OPC_LOAD;
            FMT_STORE:  opc = OPC_STORE;
            FMT_BRANCH: opc = OPC_BRANCH;
            FMT_LUI:    opc = OPC_LUI;
            FMT_AUIPC:  opc = OPC_AUIPC;
            default:    opc = OPC_ILLEGAL;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/imm_instr_encoder_legal.sv
// -----------------------------------------------------------------------------
// imm_legal_check
// Combinational check that the core's immediate extractor, when handed the
// packed word, returns exactly the requested immediate.
//   fmt    in  3   request class (6/7 are never legal)
//   funct3 in  3   selects zero/sign extension and shift rules
//   imm    in  32  immediate the extractor must reproduce
//   legal  out 1   1 when the immediate round-trips unchanged
// -----------------------------------------------------------------------------
module imm_legal_check
    import imm_instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        legal
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    // Each class is judged against the widening its extractor applies; a
    // branch offset must also be even because bit 0 is never encoded.
    always_comb begin
        legal = 1'b0;
        case (fmt)
            FMT_OP_IMM: begin
                if (funct3 == F3_SLTIU) begin
                    legal = (imm <= ZEXT12_MAX);
                end else if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
                    legal = (imm[31:12] == 20'd0) &&
                            (imm[11:5] == SHIFT_HI_LOGICAL || imm[11:5] == SHIFT_HI_ARITH);
                end else begin
                    legal = (simm >= SEXT12_MIN) && (simm <= SEXT12_MAX);
                end
            end
            FMT_LOAD, FMT_STORE: begin
                legal = (imm <= ZEXT12_MAX);
            end
            FMT_BRANCH: begin
                if (funct3[2:1] == 2'b11) begin
                    legal = !imm[0] && (imm <= BR_ZEXT_MAX);
                end else begin
                    legal = !imm[0] && (simm >= BR_SEXT_MIN) && (simm <= BR_SEXT_MAX);
                end
            end
            FMT_LUI, FMT_AUIPC: begin
                legal = (imm[11:0] == 12'd0);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// -----------------------------------------------------------------------------
// imm_instr_encoder
// Packs class, register fields, funct3 and a 32-bit immediate into an RV32I
// instruction word through a two-stage valid/ready pipeline, flagging any
// immediate the core's extractor could not reproduce.
//   clk, rst              clock / synchronous active-high reset
//   in_valid, in_ready    request handshake
//   in_fmt, in_funct3     class and funct3
//   in_rd, in_rs1, in_rs2 register fields
//   in_imm                immediate as the extractor must return it
//   out_valid, out_ready  word handshake
//   out_instr, out_err    packed word and not-representable flag
//   cnt_clr               clears both statistics counters
//   enc_cnt, err_cnt      saturating handoff / error-handoff counters
// -----------------------------------------------------------------------------
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;
    logic        s1_legal;
    logic [31:0] s1_word;
    logic [6:0]  s1_opc;
    logic        s2_load;
    logic        handoff;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign handoff  = out_valid && out_ready;

    // Stage 1 valid bit: refilled (or emptied) whenever it can hand on or is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload only needs capturing on an accepted request; its
    // contents are meaningless while s1_valid is low, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_fmt    <= in_fmt;
            s1_funct3 <= in_funct3;
            s1_rd     <= in_rd;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_imm    <= in_imm;
        end
    end

    imm_legal_check u_legal (
        .fmt    (s1_fmt),
        .funct3 (s1_funct3),
        .imm    (s1_imm),
        .legal  (s1_legal)
    );

    assign s1_opc = fmt_opcode(s1_fmt);

    // Field packing follows the standard RV32 layouts. Illegal classes still
    // produce a word (I layout, zero opcode) so the consumer sees something
    // deterministic alongside the error flag.
    always_comb begin
        s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opc};
        case (s1_fmt)
            FMT_STORE: begin
                s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opc};
            end
            FMT_BRANCH: begin
                s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:1], s1_imm[11], s1_opc};
            end
            FMT_LUI, FMT_AUIPC: begin
                s1_word = {s1_imm[31:12], s1_rd, s1_opc};
            end
            default: begin
                s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opc};
            end
        endcase
    end

    // Stage 2 holds its contents untouched while the consumer stalls it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_word;
                out_err   <= !s1_legal;
            end
        end
    end

    // Statistics: a clear beats a simultaneous increment, and both counters
    // stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (handoff) begin
            if (enc_cnt != '1) begin
                enc_cnt <= enc_cnt + 1'b1;
            end
            if (out_err && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_instr_encoder
// Directed checks of imm_instr_encoder: reset values, packing of each layout,
// legality boundaries, back-pressure, extractor round-trip, counter
// saturation/clear and reset with a full pipeline.
// -----------------------------------------------------------------------------
module tb_imm_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        cnt_clr;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;

    imm_instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // The core's immediate extractor, decoding purely from the word.
    function automatic logic [31:0] extractImm(input logic [31:0] w);
        logic [12:0] b;
        logic [31:0] r;
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        case (w[6:0])
            7'b0010011: begin
                if (w[14:12] == 3'b011 || w[14:12] == 3'b001 || w[14:12] == 3'b101)
                    r = {20'd0, w[31:20]};
                else
                    r = {{20{w[31]}}, w[31:20]};
            end
            7'b0000011: r = {20'd0, w[31:20]};
            7'b0100011: r = {20'd0, w[31:25], w[11:7]};
            7'b1100011: begin
                if (w[14:13] == 2'b11) r = {19'd0, b};
                else                   r = {{19{b[12]}}, b};
            end
            7'b0110111, 7'b0010111: r = {w[31:12], 12'd0};
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    // Sends one request into an empty pipeline with out_ready high and
    // returns the word, checking it appears exactly two edges after acceptance.
    task automatic applyStimulus(input logic [2:0] fmt, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 output logic [31:0] instr, output logic err);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_funct3 = f3;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("lat1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat2", {31'd0, out_valid}, 32'd1);
        instr = out_instr;
        err   = out_err;
    endtask

    task automatic runVec(input string tag, input logic [2:0] fmt, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic chkWord,
                          input logic [31:0] expWord, input logic expErr);
        logic [31:0] w;
        logic        e;
        applyStimulus(fmt, f3, rd, rs1, rs2, imm, w, e);
        if (chkWord) checkOutput({tag, "_instr"}, w, expWord);
        checkOutput({tag, "_err"}, {31'd0, e}, {31'd0, expErr});
    endtask

    initial begin
        logic [31:0] expq[$];
        logic [31:0] w;
        logic [31:0] imm;
        logic [31:0] prevInstr;
        logic [6:0]  expOpc;
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic        e;
        logic        prevStall;
        int          sent;
        int          got;

        rst = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_funct3 = 3'd0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_instr", out_instr,          32'd0);
        checkOutput("rst_out_err",   {31'd0, out_err},   32'd0);
        checkOutput("rst_enc_cnt",   {16'd0, enc_cnt},   32'd0);
        checkOutput("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
        rst = 1'b0;

        // Packing and legality vectors, hand-computed.
        runVec("addi_m1",   3'd0, 3'b000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF10093, 1'b0);
        runVec("beq_m4",    3'd3, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, 1'b0);
        runVec("bltu_m4",   3'd3, 3'b110, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 32'd0, 1'b1);
        runVec("beq_odd",   3'd3, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3,        1'b0, 32'd0, 1'b1);
        runVec("sw_4095",   3'd2, 3'b010, 5'd0, 5'd5, 5'd6, 32'd4095,     1'b1, 32'hFE62AFA3, 1'b0);
        runVec("sw_4096",   3'd2, 3'b010, 5'd0, 5'd5, 5'd6, 32'd4096,     1'b0, 32'd0, 1'b1);
        runVec("lui_ok",    3'd4, 3'b000, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123451B7, 1'b0);
        runVec("lui_low",   3'd4, 3'b000, 5'd3, 5'd0, 5'd0, 32'h12345001, 1'b0, 32'd0, 1'b1);
        runVec("auipc",     3'd5, 3'b000, 5'd7, 5'd0, 5'd0, 32'hFFFFF000, 1'b1, 32'hFFFFF397, 1'b0);
        runVec("addi_2047", 3'd0, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2047,     1'b0, 32'd0, 1'b0);
        runVec("addi_2048", 3'd0, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2048,     1'b0, 32'd0, 1'b1);
        runVec("addi_n2048",3'd0, 3'b100, 5'd1, 5'd1, 5'd0, 32'hFFFFF800, 1'b0, 32'd0, 1'b0);
        runVec("addi_n2049",3'd0, 3'b100, 5'd1, 5'd1, 5'd0, 32'hFFFFF7FF, 1'b0, 32'd0, 1'b1);
        runVec("srai_ok",   3'd0, 3'b101, 5'd1, 5'd1, 5'd0, 32'h0000041F, 1'b0, 32'd0, 1'b0);
        runVec("srxi_bad",  3'd0, 3'b101, 5'd1, 5'd1, 5'd0, 32'h0000021F, 1'b0, 32'd0, 1'b1);
        runVec("sltiu_max", 3'd0, 3'b011, 5'd1, 5'd1, 5'd0, 32'd4095,     1'b0, 32'd0, 1'b0);
        runVec("sltiu_neg", 3'd0, 3'b011, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b1);
        runVec("bgeu_8190", 3'd3, 3'b111, 5'd0, 5'd1, 5'd2, 32'd8190,     1'b0, 32'd0, 1'b0);
        runVec("bgeu_8192", 3'd3, 3'b111, 5'd0, 5'd1, 5'd2, 32'd8192,     1'b0, 32'd0, 1'b1);
        runVec("bne_4094",  3'd3, 3'b001, 5'd0, 5'd1, 5'd2, 32'd4094,     1'b0, 32'd0, 1'b0);
        runVec("bne_4096",  3'd3, 3'b001, 5'd0, 5'd1, 5'd2, 32'd4096,     1'b0, 32'd0, 1'b1);
        runVec("blt_n4096", 3'd3, 3'b100, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 1'b0, 32'd0, 1'b0);
        runVec("illegal6",  3'd6, 3'b000, 5'd1, 5'd1, 5'd0, 32'd0,        1'b0, 32'd0, 1'b1);

        // Back-to-back LOAD stream with the consumer stalled for three cycles.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        sent = 0; got = 0; prevStall = 1'b0; prevInstr = 32'd0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            in_valid  = (sent < 6);
            in_fmt    = 3'd1;
            in_funct3 = 3'b010;
            in_rd     = 5'(sent + 1);
            in_rs1    = 5'd4;
            in_rs2    = 5'd0;
            in_imm    = 32'(sent * 16 + 3);
            out_ready = !(c >= 2 && c < 5);
            #1;
            if (prevStall) begin
                checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("hold_instr", out_instr, prevInstr);
            end
            if (c == 2) checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (expq.size() > 0) checkOutput("stream_word", out_instr, expq.pop_front());
                else                 checkOutput("stream_extra", 32'd1, 32'd0);
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back({in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011});
                sent++;
            end
            prevStall = out_valid && !out_ready;
            prevInstr = out_instr;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_got",  32'(got), 32'd6);
        checkOutput("stream_enc",  {16'd0, enc_cnt}, 32'd6);
        checkOutput("stream_errc", {16'd0, err_cnt}, 32'd0);

        // Round-trip of random legal requests through the extractor model.
        for (int i = 0; i < 24; i++) begin
            fmt = 3'($urandom_range(0, 5));
            f3  = 3'($urandom_range(0, 7));
            case (fmt)
                3'd0: begin
                    if (f3 == 3'b011)
                        imm = 32'($urandom_range(0, 4095));
                    else if (f3 == 3'b001 || f3 == 3'b101)
                        imm = {20'd0, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 31))};
                    else
                        imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                    expOpc = 7'b0010011;
                end
                3'd1: begin imm = 32'($urandom_range(0, 4095)); expOpc = 7'b0000011; end
                3'd2: begin imm = 32'($urandom_range(0, 4095)); expOpc = 7'b0100011; end
                3'd3: begin
                    if (f3 == 3'b010 || f3 == 3'b011) f3 = 3'b000;
                    if (f3[2:1] == 2'b11)
                        imm = 32'($urandom_range(0, 4095) * 2);
                    else
                        imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    expOpc = 7'b1100011;
                end
                3'd4: begin imm = $urandom() & 32'hFFFFF000; expOpc = 7'b0110111; end
                default: begin imm = $urandom() & 32'hFFFFF000; expOpc = 7'b0010111; end
            endcase
            applyStimulus(fmt, f3, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), imm, w, e);
            checkOutput("rt_imm", extractImm(w), imm);
            checkOutput("rt_opc", {25'd0, w[6:0]}, {25'd0, expOpc});
            checkOutput("rt_err", {31'd0, e}, 32'd0);
        end

        // Saturation: stream illegal-class words well past 2^16 handoffs.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr   = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd6;
        in_funct3 = 3'd0;
        in_imm    = 32'd0;
        out_ready = 1'b1;
        repeat (65545) @(posedge clk);
        @(negedge clk);
        checkOutput("sat_err_cnt", {16'd0, err_cnt}, 32'h0000FFFF);
        checkOutput("sat_enc_cnt", {16'd0, enc_cnt}, 32'h0000FFFF);
        checkOutput("illegal_opc", {25'd0, out_instr[6:0]}, 32'd0);
        checkOutput("illegal_err", {31'd0, out_err}, 32'd1);
        cnt_clr = 1'b1;
        #1;
        checkOutput("clr_handoff", {31'd0, out_valid && out_ready}, 32'd1);
        @(negedge clk);
        checkOutput("clr_enc_cnt", {16'd0, enc_cnt}, 32'd0);
        checkOutput("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
        cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("post_clr_err", {16'd0, err_cnt}, 32'd1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset with both stages occupied and the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd1;
        in_imm    = 32'd8;
        @(negedge clk);
        @(negedge clk);
        checkOutput("full_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("full_in_ready",  {31'd0, in_ready},  32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("mid_rst_out_instr", out_instr,          32'd0);
        checkOutput("mid_rst_enc_cnt",   {16'd0, enc_cnt},   32'd0);
        checkOutput("mid_rst_err_cnt",   {16'd0, err_cnt},   32'd0);
        @(negedge clk);
        checkOutput("mid_rst_drained", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
